digital_clock_param: RTL and testbench
======================================

// Module: digital_clock_param
// PURPOSE
//  Parametrised real-time clock core. It divides the system clock down to a 1 Hz tick and
//  keeps hours, minutes and seconds. It supports run/stop, time load, 12/24-hour display
//  and a latched hh:mm alarm. It replaces the fixed free-running clock and drives display
//  and alarm logic.
// PARAMETERS
//  TICK_DIV   50_000_000  clk cycles per second; legal >= 1 (1 = one tick per running cycle)
//  DIV_W      26          prescaler width; must satisfy 2**DIV_W >= TICK_DIV
// PORTS
//  clk          in   1  system clock, all logic on posedge
//  rst          in   1  synchronous reset, active-low (rst==0 at posedge resets)
//  run          in   1  1 = time advances; 0 = prescaler and counters hold
//  mode_12h     in   1  1 = hr output in 12-hour form; 0 = 24-hour form
//  set_valid    in   1  load set_hr/set_min/set_sec this cycle
//  set_hr       in   5  load value, 0..23 (always 24-hour form)
//  set_min      in   6  load value, 0..59
//  set_sec      in   6  load value, 0..59
//  alm_valid    in   1  load alm_hr/alm_min into the alarm registers
//  alm_hr       in   5  alarm hour, 0..23
//  alm_min      in   6  alarm minute, 0..59
//  alm_en       in   1  alarm arm; 0 clears alarm and blocks new matches
//  alm_ack      in   1  clears a latched alarm
//  sec          out  6  seconds 0..59
//  min          out  6  minutes 0..59
//  hr           out  5  0..23 (24h), or 1..12 (12h)
//  pm           out  1  1 when internal hour >= 12 (valid in both modes)
//  tick_1hz     out  1  one-cycle pulse; high in the cycle where sec shows its new value
//  day_pulse    out  1  one-cycle pulse on the 23:59:59 -> 00:00:00 wrap
//  set_err      out  1  one-cycle pulse; set or alarm load rejected as out of range
//  alarm        out  1  latched alarm flag
// BEHAVIOUR
//  Reset: div_cnt, sec, min, hr24 = 0; alarm regs = 00:00; tick_1hz, day_pulse, set_err,
//   alarm = 0. Reset overrides every other input.
//  Prescaler: when run=1, div_cnt increments. At div_cnt==TICK_DIV-1 it returns to 0 and
//   that same edge advances the time. When run=0, div_cnt holds; it is never cleared by stop.
//  Advance: sec+1. At 59, sec wraps to 0 and min advances. At min 59, min wraps and hr24
//   advances. At 23, hr24 wraps to 0. Every carry resolves in that one edge, with no
//   intermediate states visible. 23:59:59 goes to 00:00:00 in one edge.
//  Output timing: sec, min and hr24 are registers. tick_1hz and day_pulse are registered and
//   align with the updated time.
//  hr/pm decode: combinational from hr24 and mode_12h, adding no latency.
//   In 12h mode, hr = (hr24 mod 12), with 0 shown as 12. pm = (hr24 >= 12).
//   Changing mode_12h changes hr in the same cycle and never alters hr24.
//  Time load: set_valid=1 with all fields in range loads them and clears div_cnt to 0.
//   A full second then elapses before the next tick.
//   Any field out of range (sec/min > 59, hr > 23) gives no change and set_err=1 for 1 cycle.
//   Set has priority over a coincident tick; that tick is discarded, with no tick_1hz and
//   no day_pulse. Set works with run=0.
//  Alarm load: alm_valid=1 with in-range values loads both alarm fields. Out of range gives
//   no change and a set_err pulse. A coincident set and alarm error gives a single pulse.
//  Alarm match: only on a tick advance whose new time equals alm_hr:alm_min:00 while
//   alm_en=1. The result is alarm<=1 on that edge, visible with tick_1hz.
//   A time load onto the alarm time does not trigger.
//  Alarm clear: alm_ack=1 or alm_en=0 clears alarm on the next edge. A match on the same
//   edge as alm_ack sets alarm; the match wins.
//  Timing: no combinational path from any input to sec/min/tick/alarm. mode_12h reaches hr.
// STRUCTURE
//  Package clock_pkg holds SEC_W=6, MIN_W=6, HR_W=5, SEC_MAX=59, MIN_MAX=59, HR_MAX=23.
//  Sub-module mod_counter #(W, MAX) has ports clk, rst, load, load_val, inc, q, wrap.
//   wrap = inc && q==MAX. It is instanced for sec, min and hr24, chained by wrap -> inc.
//  Prescaler, set/alarm validation, the 12h decode and the alarm latch live in the top level.
// TESTING (TICK_DIV=4 unless noted)
//  Reset low 3 cycles, then run=1 -> 00:00:00; tick_1hz every 4th cycle; sec 0,1,2...
//  Set 23:59:58, run -> after 2 ticks 00:00:00 with day_pulse=1 for 1 cycle, pm 1 -> 0.
//  mode_12h=1 at hr24 0, 12, 13 -> hr 12/pm0, 12/pm1, 1/pm1; at 11 -> 11/pm0.
//  Set sec=60, then hr=24 -> set_err pulses, time unchanged. A set coincident with a tick
//   loads the set value, with no tick_1hz; the next tick follows 4 cycles later.
//  Alarm 07:00, set 06:59:58, alm_en=1 -> alarm rises with the tick showing 07:00:00.
//   alm_ack clears it. A repeat with alm_en=0 gives no alarm. Set to 07:00:00 gives no alarm.
//  run=0 mid-count for 10 cycles -> time and div_cnt hold; resume, next tick after the
//   remaining cycles. rst=0 mid-count -> all outputs zero the next cycle.

Source files
------------

// File: rtl/digital_clock_param_pkg.sv
// Shared widths, limits and helpers for the real-time clock core.
package clock_pkg;

   localparam int SEC_W   = 6;
   localparam int MIN_W   = 6;
   localparam int HR_W    = 5;
   localparam int SEC_MAX = 59;
   localparam int MIN_MAX = 59;
   localparam int HR_MAX  = 23;

   // Converts an internal 0..23 hour to the 1..12 display form (midnight and noon show 12).
   function automatic logic [HR_W-1:0] to_12h(input logic [HR_W-1:0] h24);
      if (h24 == '0) begin
         return HR_W'(12);
      end else if (h24 > HR_W'(12)) begin
         return h24 - HR_W'(12);
      end else begin
         return h24;
      end
   endfunction

endpackage

// File: rtl/digital_clock_param_if.sv
// Control/status bundle between the clock core and its user (display, alarm, set logic).
interface digital_clock_param_if;
   import clock_pkg::*;

   logic             run;
   logic             mode_12h;
   logic             set_valid;
   logic [HR_W-1:0]  set_hr;
   logic [MIN_W-1:0] set_min;
   logic [SEC_W-1:0] set_sec;
   logic             alm_valid;
   logic [HR_W-1:0]  alm_hr;
   logic [MIN_W-1:0] alm_min;
   logic             alm_en;
   logic             alm_ack;

   logic [SEC_W-1:0] sec;
   logic [MIN_W-1:0] min;
   logic [HR_W-1:0]  hr;
   logic             pm;
   logic             tick_1hz;
   logic             day_pulse;
   logic             set_err;
   logic             alarm;

   // The user side drives controls and observes time/status.
   modport master (
      output run, mode_12h, set_valid, set_hr, set_min, set_sec,
             alm_valid, alm_hr, alm_min, alm_en, alm_ack,
      input  sec, min, hr, pm, tick_1hz, day_pulse, set_err, alarm
   );

   // The clock core consumes controls and produces time/status.
   modport slave (
      input  run, mode_12h, set_valid, set_hr, set_min, set_sec,
             alm_valid, alm_hr, alm_min, alm_en, alm_ack,
      output sec, min, hr, pm, tick_1hz, day_pulse, set_err, alarm
   );

endinterface

// File: rtl/digital_clock_param_counter.sv
// Loadable modulo counter; wrap flags the increment that rolls MAX back to zero so that
// instances can be chained into a carry ripple resolved within one edge.
module mod_counter #(
   parameter int W   = 6,
   parameter int MAX = 59
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         inc,
   output logic [W-1:0] q,
   output logic         wrap
);

   assign wrap = inc && (q == W'(MAX));

   // Load beats increment; increment rolls over at MAX.
   always_ff @(posedge clk) begin
      if (!rst) begin
         q <= '0;
      end else if (load) begin
         q <= load_val;
      end else if (inc) begin
         q <= (q == W'(MAX)) ? '0 : q + W'(1);
      end
   end

endmodule

// File: rtl/digital_clock_param.sv
// Real-time clock core: prescaler down to 1 Hz, hh:mm:ss counters, time load,
// 12/24-hour display decode and a latched hh:mm alarm.
module digital_clock_param
   import clock_pkg::*;
#(
   parameter int TICK_DIV = 50_000_000,
   parameter int DIV_W    = 26
) (
   input  logic                 clk,
   input  logic                 rst,
   digital_clock_param_if.slave bus
);

   logic [DIV_W-1:0] div_cnt;
   logic             tick_due;
   logic             advance;
   logic             set_ok;
   logic             set_bad;
   logic             alm_ok;
   logic             alm_bad;
   logic             alm_match;

   logic [SEC_W-1:0] sec_q;
   logic [MIN_W-1:0] min_q;
   logic [HR_W-1:0]  hr24_q;
   logic             sec_wrap;
   logic             min_wrap;
   logic             hr_wrap;

   logic [MIN_W-1:0] next_min;
   logic [HR_W-1:0]  next_hr;

   logic [HR_W-1:0]  alm_hr_q;
   logic [MIN_W-1:0] alm_min_q;
   logic             tick_q;
   logic             day_q;
   logic             err_q;
   logic             alarm_q;

   // Decode tick, load validity and the time the next tick would show.
   always_comb begin
      tick_due = bus.run && (div_cnt == DIV_W'(TICK_DIV - 1));
      set_ok   = bus.set_valid &&
                 (bus.set_hr  <= HR_W'(HR_MAX))  &&
                 (bus.set_min <= MIN_W'(MIN_MAX)) &&
                 (bus.set_sec <= SEC_W'(SEC_MAX));
      set_bad  = bus.set_valid && !set_ok;
      alm_ok   = bus.alm_valid &&
                 (bus.alm_hr  <= HR_W'(HR_MAX)) &&
                 (bus.alm_min <= MIN_W'(MIN_MAX));
      alm_bad  = bus.alm_valid && !alm_ok;
      advance  = tick_due && !set_ok;
      next_min = (min_q == MIN_W'(MIN_MAX)) ? '0 : min_q + MIN_W'(1);
      if (min_q == MIN_W'(MIN_MAX)) begin
         next_hr = (hr24_q == HR_W'(HR_MAX)) ? '0 : hr24_q + HR_W'(1);
      end else begin
         next_hr = hr24_q;
      end
      alm_match = advance && bus.alm_en &&
                  (sec_q == SEC_W'(SEC_MAX)) &&
                  (next_min == alm_min_q) &&
                  (next_hr == alm_hr_q);
   end

   // Prescaler: a time load restarts the second, stop simply freezes the count.
   always_ff @(posedge clk) begin
      if (!rst) begin
         div_cnt <= '0;
      end else if (set_ok) begin
         div_cnt <= '0;
      end else if (bus.run) begin
         div_cnt <= tick_due ? '0 : div_cnt + DIV_W'(1);
      end
   end

   mod_counter #(.W(SEC_W), .MAX(SEC_MAX)) u_sec (
      .clk      (clk),
      .rst      (rst),
      .load     (set_ok),
      .load_val (bus.set_sec),
      .inc      (advance),
      .q        (sec_q),
      .wrap     (sec_wrap)
   );

   mod_counter #(.W(MIN_W), .MAX(MIN_MAX)) u_min (
      .clk      (clk),
      .rst      (rst),
      .load     (set_ok),
      .load_val (bus.set_min),
      .inc      (sec_wrap),
      .q        (min_q),
      .wrap     (min_wrap)
   );

   mod_counter #(.W(HR_W), .MAX(HR_MAX)) u_hr (
      .clk      (clk),
      .rst      (rst),
      .load     (set_ok),
      .load_val (bus.set_hr),
      .inc      (min_wrap),
      .q        (hr24_q),
      .wrap     (hr_wrap)
   );

   // Status pulses are registered so they line up with the updated time.
   always_ff @(posedge clk) begin
      if (!rst) begin
         tick_q <= 1'b0;
         day_q  <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         tick_q <= advance;
         day_q  <= hr_wrap;
         err_q  <= set_bad || alm_bad;
      end
   end

   // Alarm time registers accept only in-range values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         alm_hr_q  <= '0;
         alm_min_q <= '0;
      end else if (alm_ok) begin
         alm_hr_q  <= bus.alm_hr;
         alm_min_q <= bus.alm_min;
      end
   end

   // Alarm latch: a fresh match wins over an acknowledge in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         alarm_q <= 1'b0;
      end else if (alm_match) begin
         alarm_q <= 1'b1;
      end else if (bus.alm_ack || !bus.alm_en) begin
         alarm_q <= 1'b0;
      end
   end

   assign bus.sec       = sec_q;
   assign bus.min       = min_q;
   assign bus.hr        = bus.mode_12h ? to_12h(hr24_q) : hr24_q;
   assign bus.pm        = (hr24_q >= HR_W'(12));
   assign bus.tick_1hz  = tick_q;
   assign bus.day_pulse = day_q;
   assign bus.set_err   = err_q;
   assign bus.alarm     = alarm_q;

endmodule

// File: tb/tb_digital_clock_param.sv
// Bench for digital_clock_param: a seconds-of-day reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_digital_clock_param;

   localparam int TICK_DIV = 4;
   localparam int DIV_W    = 3;
   localparam int DAY      = 86400;

   logic clk;
   logic rst;

   digital_clock_param_if bus ();

   digital_clock_param #(.TICK_DIV(TICK_DIV), .DIV_W(DIV_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int assertions = 0;
   int failures   = 0;

   // Reference model state: time as seconds since midnight.
   int m_valid = 0;
   int m_div   = 0;
   int m_t     = 0;
   int m_ah    = 0;
   int m_am    = 0;
   int m_alarm = 0;
   int m_tick  = 0;
   int m_day   = 0;
   int m_err   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string name, input int actual, input int expected);
      assertions++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Model update on each edge, then compare all outputs just after it.
   always @(posedge clk) begin
      int  set_ok_m, set_bad_m, alm_ok_m, alm_bad_m, tick_m, match_m, h, exp_hr;
      if (!rst) begin
         m_valid = 1;
         m_div = 0; m_t = 0; m_ah = 0; m_am = 0;
         m_alarm = 0; m_tick = 0; m_day = 0; m_err = 0;
      end else begin
         set_ok_m  = bus.set_valid && bus.set_hr <= 23 && bus.set_min <= 59 && bus.set_sec <= 59;
         set_bad_m = bus.set_valid && !set_ok_m;
         alm_ok_m  = bus.alm_valid && bus.alm_hr <= 23 && bus.alm_min <= 59;
         alm_bad_m = bus.alm_valid && !alm_ok_m;
         tick_m    = bus.run && (m_div == TICK_DIV - 1);
         match_m   = 0;
         if (set_ok_m) begin
            m_t    = bus.set_hr * 3600 + bus.set_min * 60 + bus.set_sec;
            m_div  = 0;
            m_tick = 0;
            m_day  = 0;
         end else begin
            if (bus.run) m_div = tick_m ? 0 : m_div + 1;
            if (tick_m) begin
               m_t    = (m_t + 1) % DAY;
               m_tick = 1;
               m_day  = (m_t == 0);
               match_m = bus.alm_en && (m_t == m_ah * 3600 + m_am * 60);
            end else begin
               m_tick = 0;
               m_day  = 0;
            end
         end
         if (match_m) m_alarm = 1;
         else if (bus.alm_ack || !bus.alm_en) m_alarm = 0;
         if (alm_ok_m) begin
            m_ah = bus.alm_hr;
            m_am = bus.alm_min;
         end
         m_err = set_bad_m || alm_bad_m;
      end
      #1;
      if (m_valid != 0) begin
         h = m_t / 3600;
         exp_hr = bus.mode_12h ? ((h % 12 == 0) ? 12 : h % 12) : h;
         check_output("sec",       int'(bus.sec),       m_t % 60);
         check_output("min",       int'(bus.min),       (m_t / 60) % 60);
         check_output("hr",        int'(bus.hr),        exp_hr);
         check_output("pm",        int'(bus.pm),        int'(h >= 12));
         check_output("tick_1hz",  int'(bus.tick_1hz),  m_tick);
         check_output("day_pulse", int'(bus.day_pulse), m_day);
         check_output("set_err",   int'(bus.set_err),   m_err);
         check_output("alarm",     int'(bus.alarm),     m_alarm);
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #2;
   endtask

   task automatic load_time(input int h, input int m, input int s);
      bus.set_valid = 1'b1;
      bus.set_hr    = 5'(h);
      bus.set_min   = 6'(m);
      bus.set_sec   = 6'(s);
      next_cycle();
      bus.set_valid = 1'b0;
   endtask

   task automatic load_alarm(input int h, input int m);
      bus.alm_valid = 1'b1;
      bus.alm_hr    = 5'(h);
      bus.alm_min   = 6'(m);
      next_cycle();
      bus.alm_valid = 1'b0;
   endtask

   // One randomized cycle of control traffic.
   task automatic apply_stimulus();
      int r;
      int ah, am;
      r = $urandom_range(0, 999);
      bus.run      = ($urandom_range(0, 9) != 0);
      bus.mode_12h = $urandom_range(0, 1);
      bus.alm_en   = ($urandom_range(0, 19) != 0);
      bus.alm_ack  = ($urandom_range(0, 29) == 0);
      bus.set_valid = ($urandom_range(0, 59) == 0);
      bus.set_hr    = 5'($urandom_range(0, 25));
      bus.set_min   = 6'($urandom_range(0, 61));
      bus.set_sec   = 6'($urandom_range(0, 61));
      bus.alm_valid = ($urandom_range(0, 79) == 0);
      bus.alm_hr    = 5'($urandom_range(0, 25));
      bus.alm_min   = 6'($urandom_range(0, 61));
      rst = (r < 3) ? 1'b0 : 1'b1;
      if (r >= 990) begin
         ah = $urandom_range(0, 23);
         am = $urandom_range(1, 59);
         bus.set_valid = 1'b0;
         load_alarm(ah, am);
         load_time(ah, am - 1, 57);
         bus.run    = 1'b1;
         bus.alm_en = 1'b1;
         bus.alm_ack = 1'b0;
         repeat (16) next_cycle();
      end else begin
         next_cycle();
      end
   endtask

   initial begin
      int found;
      int cnt;
      int hv[4];
      int ex_hr[4];
      int ex_pm[4];
      hv = '{0, 12, 13, 11};
      ex_hr = '{12, 12, 1, 11};
      ex_pm = '{0, 1, 1, 0};

      rst = 1'b0;
      bus.run = 1'b0; bus.mode_12h = 1'b0;
      bus.set_valid = 1'b0; bus.set_hr = '0; bus.set_min = '0; bus.set_sec = '0;
      bus.alm_valid = 1'b0; bus.alm_hr = '0; bus.alm_min = '0;
      bus.alm_en = 1'b0; bus.alm_ack = 1'b0;

      // Reset, then run from 00:00:00.
      repeat (3) next_cycle();
      check_output("rst_sec", int'(bus.sec), 0);
      check_output("rst_hr", int'(bus.hr), 0);
      check_output("rst_alarm", int'(bus.alarm), 0);
      rst = 1'b1;
      bus.run = 1'b1;
      repeat (3) next_cycle();
      check_output("pre_tick", int'(bus.tick_1hz), 0);
      next_cycle();
      check_output("first_tick", int'(bus.tick_1hz), 1);
      check_output("first_sec", int'(bus.sec), 1);

      // Day rollover.
      load_time(23, 59, 58);
      check_output("set_hr23", int'(bus.hr), 23);
      check_output("set_pm", int'(bus.pm), 1);
      found = 0;
      for (int i = 0; i < 20 && found == 0; i++) begin
         next_cycle();
         if (bus.day_pulse) found = 1;
      end
      check_output("day_seen", found, 1);
      check_output("day_sec", int'(bus.sec), 0);
      check_output("day_min", int'(bus.min), 0);
      check_output("day_hr", int'(bus.hr), 0);
      check_output("day_pm", int'(bus.pm), 0);
      next_cycle();
      check_output("day_one_cycle", int'(bus.day_pulse), 0);

      // 12-hour decode.
      bus.run = 1'b0;
      bus.mode_12h = 1'b1;
      for (int i = 0; i < 4; i++) begin
         load_time(hv[i], 0, 0);
         check_output("hr12", int'(bus.hr), ex_hr[i]);
         check_output("pm12", int'(bus.pm), ex_pm[i]);
      end
      bus.mode_12h = 1'b0;

      // Rejected loads leave time untouched.
      load_time(5, 10, 60);
      check_output("err_sec60", int'(bus.set_err), 1);
      check_output("err_hold_hr", int'(bus.hr), 11);
      next_cycle();
      check_output("err_pulse_end", int'(bus.set_err), 0);
      load_time(24, 0, 0);
      check_output("err_hr24", int'(bus.set_err), 1);
      check_output("err_hold_min", int'(bus.min), 0);

      // Load coincident with a tick discards the tick.
      bus.run = 1'b1;
      load_time(0, 0, 0);
      repeat (3) next_cycle();
      load_time(5, 6, 7);
      check_output("coinc_no_tick", int'(bus.tick_1hz), 0);
      check_output("coinc_sec", int'(bus.sec), 7);
      repeat (3) next_cycle();
      check_output("coinc_wait", int'(bus.tick_1hz), 0);
      next_cycle();
      check_output("coinc_next_tick", int'(bus.tick_1hz), 1);
      check_output("coinc_next_sec", int'(bus.sec), 8);

      // Alarm match, acknowledge, disabled repeat, load onto alarm time.
      bus.alm_en = 1'b1;
      load_alarm(7, 0);
      load_time(6, 59, 58);
      found = 0;
      for (int i = 0; i < 20 && found == 0; i++) begin
         next_cycle();
         if (bus.alarm) found = 1;
      end
      check_output("alarm_seen", found, 1);
      check_output("alarm_hr", int'(bus.hr), 7);
      check_output("alarm_min", int'(bus.min), 0);
      check_output("alarm_sec", int'(bus.sec), 0);
      check_output("alarm_tick", int'(bus.tick_1hz), 1);
      bus.alm_ack = 1'b1;
      next_cycle();
      bus.alm_ack = 1'b0;
      check_output("alarm_ack", int'(bus.alarm), 0);
      bus.alm_en = 1'b0;
      load_time(6, 59, 58);
      cnt = 0;
      repeat (16) begin
         next_cycle();
         if (bus.alarm) cnt++;
      end
      check_output("alarm_disabled", cnt, 0);
      bus.alm_en = 1'b1;
      load_time(7, 0, 0);
      cnt = 0;
      repeat (3) begin
         next_cycle();
         if (bus.alarm) cnt++;
      end
      check_output("alarm_on_load", cnt, 0);

      // Stop mid-second holds everything; resume finishes the second.
      load_time(1, 2, 3);
      repeat (2) next_cycle();
      bus.run = 1'b0;
      repeat (10) next_cycle();
      check_output("hold_sec", int'(bus.sec), 3);
      bus.run = 1'b1;
      next_cycle();
      check_output("resume_wait", int'(bus.tick_1hz), 0);
      next_cycle();
      check_output("resume_tick", int'(bus.tick_1hz), 1);
      check_output("resume_sec", int'(bus.sec), 4);

      // Reset mid-count.
      repeat (2) next_cycle();
      rst = 1'b0;
      next_cycle();
      check_output("midrst_sec", int'(bus.sec), 0);
      check_output("midrst_min", int'(bus.min), 0);
      check_output("midrst_hr", int'(bus.hr), 0);
      rst = 1'b1;

      // Randomized traffic against the model.
      repeat (3000) apply_stimulus();
      rst = 1'b1;
      next_cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
